// File: rtl/issue_ctrl_if.sv
// Decode-to-issue request and writeback handshake bundle for issue_ctrl.
interface issue_ctrl_if;
   logic        dec_valid;
   logic [2:0]  dec_op;
   logic [2:0]  dec_funct;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic        dec_rwe;
   logic        dec_fwe;
   logic        flush;
   logic        issue;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_fp;
   logic [1:0]  wb_src;
   logic [31:0] stall_cycles;

   modport master (
      output dec_valid, dec_op, dec_funct, dec_rs1, dec_rs2,
      output dec_rd, dec_rwe, dec_fwe, flush,
      input  issue, stall, wb_valid, wb_rd, wb_fp, wb_src,
      input  stall_cycles
   );

   modport slave (
      input  dec_valid, dec_op, dec_funct, dec_rs1, dec_rs2,
      input  dec_rd, dec_rwe, dec_fwe, flush,
      output issue, stall, wb_valid, wb_rd, wb_fp, wb_src,
      output stall_cycles
   );
endinterface

// File: rtl/issue_ctrl.sv
// Issue scheduler: busy-bit scoreboard plus writeback-slot reservation.
// Define WB_BYPASS_EN to let RAW consumers issue in the producer's wb cycle.
module issue_ctrl #(
   parameter int FPU_LAT = 3,
   parameter int MEM_LAT = 2
) (
   input logic         clk,
   input logic         rst,
   issue_ctrl_if.slave io
);
   localparam int LBIG = (FPU_LAT > MEM_LAT) ? FPU_LAT : MEM_LAT;
   localparam int LMAX = (LBIG > 1) ? LBIG : 1;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       fp;
      logic [1:0] src;
   } res_t;

   res_t             res_q [1:LMAX];
   res_t             res_d [1:LMAX];
   logic [1:0][31:0] busy_q, busy_d;
   logic [31:0]      stall_cnt_q, stall_cnt_d;

   logic       is_fpu, is_ld, src_fp, rd1, rd2, has_dst, dst_fp;
   logic       raw1, raw2, waw, slot_busy, hazard, go;
   logic       unused;
   int         lat;
   logic [1:0] src;

   assign unused = io.dec_funct[0];

   always_comb begin
      is_fpu = (io.dec_op == 3'b010);
      is_ld  = (io.dec_op == 3'b101) && (io.dec_funct[2:1] == 2'b00);
      lat    = 1;
      src    = 2'd0;
      unique case (1'b1)
         is_fpu: begin lat = FPU_LAT; src = 2'd1; end
         is_ld:  begin lat = MEM_LAT; src = 2'd2; end
         default: ;
      endcase
      src_fp  = io.dec_op inside {3'b010, 3'b011};
      rd1     = (io.dec_op != 3'b111);
      rd2     = io.dec_op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110};
      has_dst = io.dec_rwe | io.dec_fwe;
      dst_fp  = ~io.dec_rwe;
      raw1    = rd1 & busy_q[src_fp][io.dec_rs1];
      raw2    = rd2 & busy_q[src_fp][io.dec_rs2];
`ifdef WB_BYPASS_EN
      // The value being written back this cycle is forwarded by execute.
      if (res_q[1].v && (res_q[1].fp == src_fp)) begin
         if (res_q[1].rd == io.dec_rs1) raw1 = 1'b0;
         if (res_q[1].rd == io.dec_rs2) raw2 = 1'b0;
      end
`endif
      waw       = has_dst & busy_q[dst_fp][io.dec_rd];
      slot_busy = 1'b0;
      for (int k = 2; k <= LMAX; k++)
         if (k == lat + 1) slot_busy = res_q[k].v;
      hazard = raw1 | raw2 | waw | (has_dst & slot_busy);
      go     = io.dec_valid & ~io.flush;
   end

   assign io.issue = go & ~hazard;
   assign io.stall = go & hazard;

   always_comb begin
      for (int k = 1; k < LMAX; k++)
         res_d[k] = res_q[k+1];
      res_d[LMAX] = '0;
      if (io.issue && has_dst)
         for (int k = 1; k <= LMAX; k++)
            if (k == lat) res_d[k] = {1'b1, io.dec_rd, dst_fp, src};
      busy_d = busy_q;
      if (res_q[1].v) busy_d[res_q[1].fp][res_q[1].rd] = 1'b0;
      if (io.issue && has_dst) busy_d[dst_fp][io.dec_rd] = 1'b1;
      stall_cnt_d = stall_cnt_q;
      if (io.stall && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= LMAX; k++) res_q[k] <= '0;
         busy_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         res_q       <= res_d;
         busy_q      <= busy_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign io.wb_valid     = res_q[1].v;
   assign io.wb_rd        = res_q[1].rd;
   assign io.wb_fp        = res_q[1].fp;
   assign io.wb_src       = res_q[1].src;
   assign io.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl with a writeback scoreboard queue.
module tb_issue_ctrl;
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_FADD = 3'b010;
   localparam logic [2:0] OP_ADDI = 3'b100;
   localparam logic [2:0] OP_LD   = 3'b101;
   localparam int FL = 3;
   localparam int ML = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   issue_ctrl_if io ();
   issue_ctrl #(.FPU_LAT(FL), .MEM_LAT(ML)) dut (
      .clk(clk),
      .rst(rst),
      .io (io)
   );

   typedef struct {
      int         due;
      logic [4:0] rd;
      logic       fp;
      logic [1:0] src;
   } wb_t;

   wb_t         sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   logic [31:0] exp_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      int idx;
      if (mon_en) begin
         idx = -1;
         foreach (sb[i]) if (sb[i].due == cyc) idx = i;
         chk($sformatf("wb_valid@%0d", cyc), {31'd0, io.wb_valid},
             (idx >= 0) ? 32'd1 : 32'd0);
         if (idx >= 0) begin
            chk("wb_rd", {27'd0, io.wb_rd}, {27'd0, sb[idx].rd});
            chk("wb_fp", {31'd0, io.wb_fp}, {31'd0, sb[idx].fp});
            chk("wb_src", {30'd0, io.wb_src}, {30'd0, sb[idx].src});
            sb.delete(idx);
         end
      end
   end

   task automatic step(input string tag, input logic v,
                       input logic [2:0] op, input logic [2:0] funct,
                       input logic [4:0] rs1, input logic [4:0] rd,
                       input logic rwe, input logic fwe, input logic fl,
                       input logic ei, input logic es, input bit ccnt = 1);
      int         l;
      logic [1:0] s;
      io.dec_valid = v;
      io.dec_op    = op;
      io.dec_funct = funct;
      io.dec_rs1   = rs1;
      io.dec_rs2   = 5'd0;
      io.dec_rd    = rd;
      io.dec_rwe   = rwe;
      io.dec_fwe   = fwe;
      io.flush     = fl;
      l = 1;
      s = 2'd0;
      if (op == OP_FADD) begin l = FL; s = 2'd1; end
      else if (op == OP_LD && funct[2:1] == 2'b00) begin l = ML; s = 2'd2; end
      if (ei && (rwe || fwe)) sb.push_back('{cyc + l, rd, ~rwe, s});
      @(negedge clk);
      chk({tag, ".issue"}, {31'd0, io.issue}, {31'd0, ei});
      chk({tag, ".stall"}, {31'd0, io.stall}, {31'd0, es});
      if (ccnt) chk({tag, ".cnt"}, io.stall_cycles, exp_cnt);
      if (es && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string tag, input bit ccnt = 1);
      step(tag, 0, OP_ADD, 3'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, ccnt);
   endtask

   initial begin
      io.dec_valid = 0; io.dec_op = 0; io.dec_funct = 0;
      io.dec_rs1 = 0; io.dec_rs2 = 0; io.dec_rd = 0;
      io.dec_rwe = 0; io.dec_fwe = 0; io.flush = 0;
      rst = 1'b1;
      exp_cnt = 32'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;

      idle("t1");
      chk("t1.wb_rd", {27'd0, io.wb_rd}, 32'd0);
      chk("t1.wb_src", {30'd0, io.wb_src}, 32'd0);

      step("t2.prod", 1, OP_ADD, 3'd0, 5'd1, 5'd3, 1, 0, 0, 1, 0);
`ifdef WB_BYPASS_EN
      step("t2.cons", 1, OP_ADD, 3'd0, 5'd3, 5'd4, 1, 0, 0, 1, 0);
`else
      step("t2.cons0", 1, OP_ADD, 3'd0, 5'd3, 5'd4, 1, 0, 0, 0, 1);
      step("t2.cons1", 1, OP_ADD, 3'd0, 5'd3, 5'd4, 1, 0, 0, 1, 0);
`endif
      repeat (3) idle("t2.drain");

      step("t3.fadd", 1, OP_FADD, 3'd0, 5'd1, 5'd5, 0, 1, 0, 1, 0);
      idle("t3.gap");
      step("t3.add0", 1, OP_ADD, 3'd0, 5'd1, 5'd6, 1, 0, 0, 0, 1);
      step("t3.add1", 1, OP_ADD, 3'd0, 5'd1, 5'd6, 1, 0, 0, 1, 0);
      repeat (3) idle("t3.drain");

      step("t4.lw", 1, OP_LD, 3'd0, 5'd1, 5'd7, 1, 0, 0, 1, 0);
      step("t4.addi0", 1, OP_ADDI, 3'd0, 5'd1, 5'd7, 1, 0, 0, 0, 1);
      step("t4.addi1", 1, OP_ADDI, 3'd0, 5'd1, 5'd7, 1, 0, 0, 0, 1);
      step("t4.addi2", 1, OP_ADDI, 3'd0, 5'd1, 5'd7, 1, 0, 0, 1, 0);
      repeat (3) idle("t4.drain");

      step("t5.fadd", 1, OP_FADD, 3'd0, 5'd1, 5'd8, 0, 1, 0, 1, 0);
      step("t5.fl0", 1, OP_FADD, 3'd0, 5'd8, 5'd9, 0, 1, 1, 0, 0);
      step("t5.fl1", 1, OP_FADD, 3'd0, 5'd8, 5'd9, 0, 1, 1, 0, 0);
      repeat (3) idle("t5.drain");

      step("t6.fadd", 1, OP_FADD, 3'd0, 5'd1, 5'd12, 0, 1, 0, 1, 0);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      exp_cnt = 32'hFFFF_FFFE;
      step("t6.waw0", 1, OP_FADD, 3'd0, 5'd1, 5'd12, 0, 1, 0, 0, 1);
      release dut.stall_cnt_q;
      step("t6.waw1", 1, OP_FADD, 3'd0, 5'd1, 5'd12, 0, 1, 0, 0, 1, 0);
      step("t6.waw2", 1, OP_FADD, 3'd0, 5'd1, 5'd12, 0, 1, 0, 0, 1);
      step("t6.waw3", 1, OP_FADD, 3'd0, 5'd1, 5'd12, 0, 1, 0, 1, 0);
      idle("t6.hold");
      repeat (3) idle("t6.drain");

      step("t6.inflt", 1, OP_FADD, 3'd0, 5'd1, 5'd14, 0, 1, 0, 1, 0);
      rst = 1'b1;
      idle("t6.rst");
      rst = 1'b0;
      exp_cnt = 32'd0;
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].due >= cyc) sb.delete(i);
      chk("t6.wb_rd", {27'd0, io.wb_rd}, 32'd0);
      chk("t6.wb_fp", {31'd0, io.wb_fp}, 32'd0);
      chk("t6.wb_src", {30'd0, io.wb_src}, 32'd0);
      step("t6.post", 1, OP_FADD, 3'd0, 5'd14, 5'd15, 0, 1, 0, 1, 0);
      repeat (4) idle("t6.end");

      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
